// File: rtl/processor_run_controller.sv
// processor_run_controller: staggered reset release, RUN/HALT/STEP/RESET
// command handling and executed-cycle counting for the single-cycle processor.
// Optional breakpoint unit is enabled by defining RUN_CTRL_BREAKPOINT_EN.
module processor_run_controller #(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned STEP_W   = 16,
    parameter int unsigned RST_HOLD = 4,
    parameter int unsigned AUTO_RUN = 1
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic [1:0]          CMD_OP,
    input  logic [STEP_W-1:0]   CMD_ARG,
    input  logic [PC_WIDTH-1:0] PC,
`ifdef RUN_CTRL_BREAKPOINT_EN
    input  logic [PC_WIDTH-1:0] BP_ADDR,
    input  logic                BP_VALID,
    output logic                BP_HIT,
`endif
    output logic                PCRRST,
    output logic                RFRST,
    output logic                DMRST,
    output logic                CPU_EN,
    output logic [1:0]          STATE,
    output logic                HALTED,
    output logic [31:0]         CYCLE_CNT
);

    localparam int unsigned HOLD_W = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
    localparam int unsigned CNT_W  = 32;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_HALT  = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_HALT     = 2'd1,
        ST_RUN      = 2'd2,
        ST_STEP     = 2'd3
    } state_t;

    localparam state_t AUTO_STATE = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_d;
    logic [STEP_W-1:0]   step_cnt_q, step_d;
    logic                cmd_acc;
    logic                clr_cnt;
    logic                run_c;
    logic                bp_match;
    logic                cpu_en_c;
    logic                pcrrst_d;
    logic                rfrst_d;
    logic                cmd_ready_d;
    logic                halted_d;
    logic [CNT_W-1:0]    cycle_d;

    assign cmd_acc = CMD_VALID & CMD_READY;
    assign run_c   = (state_q == ST_RUN) || (state_q == ST_STEP);

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic skip_q, skip_d;
    logic bp_hit_d;

    // Breakpoint match, masked on the first cycle after resuming from HALT
    assign bp_match = run_c && BP_VALID && (PC == BP_ADDR) && !skip_q;
`else
    logic pc_unused;

    // PC is only observed by the breakpoint unit
    assign pc_unused = ^PC;
    assign bp_match  = 1'b0;
`endif

    // State and sequencing counters
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_RST_HOLD;
            hold_cnt_q <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_d;
            step_cnt_q <= step_d;
        end
    end

    // Next state: reset sequencing, then commands, then breakpoint, then step countdown
    always_comb begin
        state_d = state_q;
        hold_d  = hold_cnt_q;
        step_d  = step_cnt_q;
        clr_cnt = 1'b0;
        if (state_q == ST_RST_HOLD) begin
            if (hold_cnt_q >= HOLD_W'(RST_HOLD)) begin
                state_d = AUTO_STATE;
            end else begin
                hold_d = hold_cnt_q + HOLD_W'(1);
            end
        end else if (cmd_acc) begin
            case (CMD_OP)
                OP_RUN:  state_d = ST_RUN;
                OP_HALT: state_d = ST_HALT;
                OP_STEP: begin
                    if (CMD_ARG != '0) begin
                        state_d = ST_STEP;
                        step_d  = CMD_ARG;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
                default: begin
                    state_d = ST_RST_HOLD;
                    hold_d  = '0;
                    clr_cnt = 1'b1;
                end
            endcase
        end else if (bp_match) begin
            state_d = ST_HALT;
        end else if (state_q == ST_STEP) begin
            step_d = step_cnt_q - STEP_W'(1);
            if (step_cnt_q == STEP_W'(1)) begin
                state_d = ST_HALT;
            end
        end
    end

    // Output next-values derived from the next state; CPU_EN straight from current state
    always_comb begin
        cpu_en_c    = run_c & ~bp_match;
        pcrrst_d    = 1'b0;
        rfrst_d     = 1'b0;
        cmd_ready_d = 1'b1;
        halted_d    = (state_d == ST_HALT);
        cycle_d     = CYCLE_CNT;
        if (state_d == ST_RST_HOLD) begin
            pcrrst_d    = 1'b1;
            rfrst_d     = (hold_d < HOLD_W'(RST_HOLD));
            cmd_ready_d = 1'b0;
        end
        if (clr_cnt) begin
            cycle_d = '0;
        end else if (cpu_en_c && (CYCLE_CNT != {CNT_W{1'b1}})) begin
            cycle_d = CYCLE_CNT + CNT_W'(1);
        end
`ifdef RUN_CTRL_BREAKPOINT_EN
        skip_d   = cmd_acc && (state_q == ST_HALT) &&
                   ((CMD_OP == OP_RUN) || ((CMD_OP == OP_STEP) && (CMD_ARG != '0)));
        bp_hit_d = cmd_acc ? 1'b0 : (BP_HIT | bp_match);
`endif
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            PCRRST    <= 1'b1;
            RFRST     <= 1'b1;
            DMRST     <= 1'b1;
            CMD_READY <= 1'b0;
            HALTED    <= 1'b0;
            CYCLE_CNT <= '0;
        end else begin
            PCRRST    <= pcrrst_d;
            RFRST     <= rfrst_d;
            DMRST     <= rfrst_d;
            CMD_READY <= cmd_ready_d;
            HALTED    <= halted_d;
            CYCLE_CNT <= cycle_d;
        end
    end

`ifdef RUN_CTRL_BREAKPOINT_EN
    // Breakpoint status and resume mask
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            BP_HIT <= 1'b0;
            skip_q <= 1'b0;
        end else begin
            BP_HIT <= bp_hit_d;
            skip_q <= skip_d;
        end
    end
`endif

    assign CPU_EN = cpu_en_c;
    assign STATE  = state_q;

endmodule

// File: tb/tb_processor_run_controller.sv
// Directed bench for processor_run_controller (RST_HOLD=4, AUTO_RUN=1).
// Breakpoint steps are included when RUN_CTRL_BREAKPOINT_EN is defined.
module tb_processor_run_controller;

    logic        CLK;
    logic        RSTN;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [15:0] CMD_ARG;
    logic [31:0] PC;
    logic        PCRRST, RFRST, DMRST, CPU_EN;
    logic [1:0]  STATE;
    logic        HALTED;
    logic [31:0] CYCLE_CNT;
`ifdef RUN_CTRL_BREAKPOINT_EN
    logic [31:0] BP_ADDR;
    logic        BP_VALID;
    logic        BP_HIT;
`endif

    int checks = 0;
    int errors = 0;
    int en_cnt;

    processor_run_controller #(
        .PC_WIDTH (32),
        .STEP_W   (16),
        .RST_HOLD (4),
        .AUTO_RUN (1)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_ARG   (CMD_ARG),
        .PC        (PC),
`ifdef RUN_CTRL_BREAKPOINT_EN
        .BP_ADDR   (BP_ADDR),
        .BP_VALID  (BP_VALID),
        .BP_HIT    (BP_HIT),
`endif
        .PCRRST    (PCRRST),
        .RFRST     (RFRST),
        .DMRST     (DMRST),
        .CPU_EN    (CPU_EN),
        .STATE     (STATE),
        .HALTED    (HALTED),
        .CYCLE_CNT (CYCLE_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Processor PC model: cleared by PCRRST, advances by 4 on enabled edges
    always @(posedge CLK) begin
        if (PCRRST) PC <= 32'd0;
        else if (CPU_EN) PC <= PC + 32'd4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] arg);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_ARG   = arg;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag, input logic [31:0] cnt_exp);
        chk({tag, "_state"},  32'(STATE), 32'd0);
        chk({tag, "_pcrrst"}, 32'(PCRRST), 32'd1);
        chk({tag, "_rfrst"},  32'(RFRST), 32'd1);
        chk({tag, "_dmrst"},  32'(DMRST), 32'd1);
        chk({tag, "_cpu_en"}, 32'(CPU_EN), 32'd0);
        chk({tag, "_ready"},  32'(CMD_READY), 32'd0);
        chk({tag, "_cnt"},    CYCLE_CNT, cnt_exp);
    endtask

    // Five edges of release: RF/DM resets drop on edge 4, PC reset and RUN on edge 5
    task automatic chk_release(input string tag);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk({tag, "_rfrst"},  32'(RFRST),  (k < 4) ? 32'd1 : 32'd0);
            chk({tag, "_dmrst"},  32'(DMRST),  (k < 4) ? 32'd1 : 32'd0);
            chk({tag, "_pcrrst"}, 32'(PCRRST), (k < 5) ? 32'd1 : 32'd0);
            chk({tag, "_ready"},  32'(CMD_READY), (k < 5) ? 32'd0 : 32'd1);
            chk({tag, "_cpu_en"}, 32'(CPU_EN), (k < 5) ? 32'd0 : 32'd1);
        end
        chk({tag, "_state"}, 32'(STATE), 32'd2);
    endtask

    initial begin
        RSTN      = 1'b0;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'b00;
        CMD_ARG   = 16'd0;
`ifdef RUN_CTRL_BREAKPOINT_EN
        BP_ADDR   = 32'h0;
        BP_VALID  = 1'b0;
`endif
        repeat (3) tick();
        chk_reset_vals("por", 32'd0);
        chk("por_halted", 32'(HALTED), 32'd0);

        RSTN = 1'b1;
        chk_release("rel");
        chk("rel_cnt", CYCLE_CNT, 32'd0);

        // Ten free-running cycles
        repeat (10) tick();
        chk("run_cnt", CYCLE_CNT, 32'd10);

        // HALT: the accepting edge still counts, then frozen
        send(2'b01, 16'd0);
        chk("halt_state", 32'(STATE), 32'd1);
        chk("halt_halted", 32'(HALTED), 32'd1);
        chk("halt_cpu_en", 32'(CPU_EN), 32'd0);
        chk("halt_cnt", CYCLE_CNT, 32'd11);
        repeat (3) tick();
        chk("halt_frozen", CYCLE_CNT, 32'd11);

        // STEP 5
        send(2'b10, 16'd5);
        chk("step5_state", 32'(STATE), 32'd3);
        en_cnt = 0;
        repeat (8) begin
            if (CPU_EN) en_cnt++;
            tick();
        end
        chk("step5_en_cycles", 32'(en_cnt), 32'd5);
        chk("step5_halted", 32'(HALTED), 32'd1);
        chk("step5_cnt", CYCLE_CNT, 32'd16);

        // STEP 0 is a no-op
        send(2'b10, 16'd0);
        en_cnt = 0;
        repeat (4) begin
            if (CPU_EN) en_cnt++;
            tick();
        end
        chk("step0_state", 32'(STATE), 32'd1);
        chk("step0_en_cycles", 32'(en_cnt), 32'd0);
        chk("step0_cnt", CYCLE_CNT, 32'd16);

        // STEP 3 reloaded with STEP 2 on its second cycle
        send(2'b10, 16'd3);
        en_cnt = 0;
        if (CPU_EN) en_cnt++;
        tick();
        if (CPU_EN) en_cnt++;
        send(2'b10, 16'd2);
        repeat (6) begin
            if (CPU_EN) en_cnt++;
            tick();
        end
        chk("reload_en_cycles", 32'(en_cnt), 32'd4);
        chk("reload_halted", 32'(HALTED), 32'd1);
        chk("reload_cnt", CYCLE_CNT, 32'd20);

        // RUN up to 100 then RESET command
        send(2'b00, 16'd0);
        chk("run2_state", 32'(STATE), 32'd2);
        repeat (80) tick();
        chk("run2_cnt", CYCLE_CNT, 32'd100);
        send(2'b11, 16'd0);
        chk_reset_vals("rstcmd", 32'd0);
        // A HALT offered during the hold must be ignored
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b01;
        tick();
        chk("rstcmd_ignored_ready", 32'(CMD_READY), 32'd0);
        tick();
        tick();
        CMD_VALID = 1'b0;
        tick();
        chk("replay_rfrst", 32'(RFRST), 32'd0);
        chk("replay_pcrrst", 32'(PCRRST), 32'd1);
        tick();
        chk("replay_pcrrst_low", 32'(PCRRST), 32'd0);
        chk("replay_state", 32'(STATE), 32'd2);
        chk("replay_cnt", CYCLE_CNT, 32'd0);

        // RSTN pulsed mid-STEP
        send(2'b01, 16'd0);
        send(2'b10, 16'd10);
        tick();
        tick();
        chk("mid_step_state", 32'(STATE), 32'd3);
        RSTN = 1'b0;
        #1;
        chk_reset_vals("async", 32'd0);
        tick();
        tick();
        chk("async_hold_state", 32'(STATE), 32'd0);
        RSTN = 1'b1;
        chk_release("rel2");

`ifdef RUN_CTRL_BREAKPOINT_EN
        // Breakpoint at 0x10 with PC counting from 0
        send(2'b11, 16'd0);
        BP_ADDR  = 32'h10;
        BP_VALID = 1'b1;
        chk_release("bp_rel");
        chk("bp_pc0", PC, 32'h0);
        repeat (4) tick();
        chk("bp_pc", PC, 32'h10);
        chk("bp_cpu_en", 32'(CPU_EN), 32'd0);
        tick();
        chk("bp_state", 32'(STATE), 32'd1);
        chk("bp_hit", 32'(BP_HIT), 32'd1);
        chk("bp_cnt", CYCLE_CNT, 32'd4);
        send(2'b00, 16'd0);
        chk("bp_resume_hit", 32'(BP_HIT), 32'd0);
        chk("bp_resume_en", 32'(CPU_EN), 32'd1);
        tick();
        chk("bp_resume_pc", PC, 32'h14);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
